// File: rtl/mac_package.sv
// Shared types for the MAC control path: address-generator control/flag bundles
// and the address-generator state encoding.
package mac_package;

    localparam int MAC_ADDR_WIDTH = 32;
    localparam int MAC_CNT_WIDTH  = 16;
    localparam int MAC_LEN_WIDTH  = 16;

    localparam logic [1:0] ADDRGEN_IDLE = 2'd0;
    localparam logic [1:0] ADDRGEN_RUN  = 2'd1;
    localparam logic [1:0] ADDRGEN_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ADDRGEN_IDLE,
        RUN  = ADDRGEN_RUN,
        DONE = ADDRGEN_DONE
    } addrgen_state_t;

    typedef struct packed {
        logic                      start;
        logic [MAC_ADDR_WIDTH-1:0] base;
        logic [MAC_CNT_WIDTH-1:0]  nb_iter;
        logic [MAC_LEN_WIDTH-1:0]  len;
        logic [MAC_ADDR_WIDTH-1:0] stride;
    } ctrl_addrgen_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [MAC_CNT_WIDTH-1:0] idx;
    } flags_addrgen_t;

endpackage

// File: rtl/mac_addrgen.sv
// Vector address generator: one address/length request per vector of a job,
// issued over valid/ready, with a one-cycle done pulse at job end.
module mac_addrgen
    import mac_package::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  nb_iter_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [ADDR_WIDTH-1:0] vect_stride_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [LEN_WIDTH-1:0]  req_len_o,
    output logic                  req_last_o,
    output logic [CNT_WIDTH-1:0]  idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    logic [1:0]            state_reg,   state_next;
    logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
    logic [ADDR_WIDTH-1:0] stride_reg,  stride_next;
    logic [CNT_WIDTH-1:0]  idx_reg,     idx_next;
    logic [CNT_WIDTH-1:0]  nb_iter_reg, nb_iter_next;
    logic [LEN_WIDTH-1:0]  len_reg,     len_next;
    logic                  last_vec;

    // Only meaningful in RUN, where nb_iter_reg is known to be non-zero.
    assign last_vec = (idx_reg == nb_iter_reg - CNT_WIDTH'(1));

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        stride_next  = stride_reg;
        idx_next     = idx_reg;
        nb_iter_next = nb_iter_reg;
        len_next     = len_reg;
        if (clear_i) begin
            state_next   = ADDRGEN_IDLE;
            addr_next    = '0;
            stride_next  = '0;
            idx_next     = '0;
            nb_iter_next = '0;
            len_next     = '0;
        end else begin
            case (state_reg)
                ADDRGEN_IDLE: begin
                    if (start_i) begin
                        addr_next    = base_addr_i;
                        stride_next  = vect_stride_i;
                        nb_iter_next = nb_iter_i;
                        len_next     = len_i;
                        idx_next     = '0;
                        state_next   = (nb_iter_i == '0) ? ADDRGEN_DONE : ADDRGEN_RUN;
                    end
                end
                ADDRGEN_RUN: begin
                    if (req_ready_i) begin
                        if (last_vec) begin
                            state_next = ADDRGEN_DONE;
                        end else begin
                            addr_next = addr_reg + stride_reg;
                            idx_next  = idx_reg + CNT_WIDTH'(1);
                        end
                    end
                end
                ADDRGEN_DONE: state_next = ADDRGEN_IDLE;
                default:      state_next = ADDRGEN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ADDRGEN_IDLE;
            addr_reg    <= '0;
            stride_reg  <= '0;
            idx_reg     <= '0;
            nb_iter_reg <= '0;
            len_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            stride_reg  <= stride_next;
            idx_reg     <= idx_next;
            nb_iter_reg <= nb_iter_next;
            len_reg     <= len_next;
        end
    end

    // Every output decodes registered state only, so ready never reaches an output.
    assign req_valid_o = (state_reg == ADDRGEN_RUN);
    assign req_addr_o  = addr_reg;
    assign req_len_o   = len_reg;
    assign req_last_o  = (state_reg == ADDRGEN_RUN) && last_vec;
    assign idx_o       = idx_reg;
    assign busy_o      = (state_reg != ADDRGEN_IDLE);
    assign done_o      = (state_reg == ADDRGEN_DONE);

endmodule

// File: tb/tb_mac_addrgen.sv
// Self-checking bench for mac_addrgen: directed and randomized jobs checked
// against an expected-request queue built from the job parameters.
module tb_mac_addrgen;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] nb_iter_i;
    logic [15:0] len_i;
    logic [31:0] vect_stride_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic [15:0] req_len_o;
    logic        req_last_o;
    logic [15:0] idx_o;
    logic        busy_o;
    logic        done_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
        logic        last;
        logic [15:0] idx;
    } req_t;

    req_t exp_q[$];

    always #5 clk_i = ~clk_i;

    mac_addrgen #(.ADDR_WIDTH(32), .CNT_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .nb_iter_i     (nb_iter_i),
        .len_i         (len_i),
        .vect_stride_i (vect_stride_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .req_len_o     (req_len_o),
        .req_last_o    (req_last_o),
        .idx_o         (idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(req_valid_o), 32'd0);
        chk({tag, ".addr"},  req_addr_o,       32'd0);
        chk({tag, ".len"},   32'(req_len_o),   32'd0);
        chk({tag, ".last"},  32'(req_last_o),  32'd0);
        chk({tag, ".idx"},   32'(idx_o),       32'd0);
        chk({tag, ".busy"},  32'(busy_o),      32'd0);
        chk({tag, ".done"},  32'(done_o),      32'd0);
    endtask

    // Expected request list straight from the job definition.
    task automatic build_model(input logic [31:0] base, input logic [15:0] n,
                               input logic [15:0] len, input logic [31:0] stride);
        req_t r;
        exp_q.delete();
        for (int k = 0; k < int'(n); k++) begin
            r.addr = base + 32'(k) * stride;
            r.len  = len;
            r.last = (k == int'(n) - 1);
            r.idx  = 16'(k);
            exp_q.push_back(r);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1-0-0-1, 2 = random.
    // perturb: scramble inputs and pulse start while the job runs.
    task automatic run_job(input string tag, input logic [31:0] base, input logic [15:0] n,
                           input logic [15:0] len, input logic [31:0] stride,
                           input int ready_mode, input bit perturb);
        bit done_seen = 0;
        int cyc = 0;
        int hs = 0;
        build_model(base, n, len, stride);
        base_addr_i   = base;
        nb_iter_i     = n;
        len_i         = len;
        vect_stride_i = stride;
        start_i       = 1'b1;
        req_ready_i   = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!done_seen && cyc < 300) begin
            chk({tag, ".valid"}, 32'(req_valid_o), 32'(exp_q.size() != 0));
            chk({tag, ".done"},  32'(done_o),      32'(exp_q.size() == 0));
            chk({tag, ".busy"},  32'(busy_o),      32'd1);
            if (exp_q.size() != 0) begin
                chk({tag, ".addr"}, req_addr_o,      exp_q[0].addr);
                chk({tag, ".len"},  32'(req_len_o),  32'(exp_q[0].len));
                chk({tag, ".last"}, 32'(req_last_o), 32'(exp_q[0].last));
                chk({tag, ".idx"},  32'(idx_o),      32'(exp_q[0].idx));
                case (ready_mode)
                    0:       req_ready_i = 1'b1;
                    1:       req_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: req_ready_i = 1'($urandom_range(0, 1));
                endcase
                if (req_ready_i) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
                if (perturb) begin
                    base_addr_i   = $urandom;
                    nb_iter_i     = 16'($urandom);
                    len_i         = 16'($urandom);
                    vect_stride_i = $urandom;
                    start_i       = 1'($urandom_range(0, 1));
                end
            end else begin
                done_seen   = 1;
                start_i     = 1'b0;
                req_ready_i = 1'b0;
            end
            cyc++;
            @(negedge clk_i);
        end
        start_i     = 1'b0;
        req_ready_i = 1'b0;
        chk({tag, ".timeout"}, 32'(done_seen), 32'd1);
        chk({tag, ".handshakes"}, 32'(hs), 32'(n));
        chk({tag, ".idle_busy"},  32'(busy_o),      32'd0);
        chk({tag, ".idle_done"},  32'(done_o),      32'd0);
        chk({tag, ".idle_valid"}, 32'(req_valid_o), 32'd0);
        $display("job %s base=%h n=%0d len=%0d stride=%h mode=%0d cycles=%0d", tag, base, n, len, stride, ready_mode, cyc);
    endtask

    // Start a 5-vector job, abort it while the 2nd request is on the bus.
    task automatic abort_job(input string tag, input bit use_rst);
        base_addr_i   = 32'h0000_2000;
        nb_iter_i     = 16'd5;
        len_i         = 16'd3;
        vect_stride_i = 32'h10;
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        req_ready_i = 1'b1;
        chk({tag, ".first_idx"}, 32'(idx_o), 32'd0);
        @(negedge clk_i);
        req_ready_i = 1'b0;
        chk({tag, ".second_idx"},  32'(idx_o),      32'd1);
        chk({tag, ".second_addr"}, req_addr_o,      32'h0000_2010);
        if (use_rst) begin
            rst_ni = 1'b0;
            #1;
            chk_zero({tag, ".async"});
            @(negedge clk_i);
            rst_ni = 1'b1;
        end else begin
            clear_i = 1'b1;
            req_ready_i = 1'b1;
            @(negedge clk_i);
            clear_i = 1'b0;
            req_ready_i = 1'b0;
        end
        chk_zero({tag, ".after"});
        @(negedge clk_i);
        chk_zero({tag, ".later"});
        $display("abort %s done", tag);
    endtask

    initial begin
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        start_i       = 1'b0;
        req_ready_i   = 1'b0;
        base_addr_i   = '0;
        nb_iter_i     = '0;
        len_i         = '0;
        vect_stride_i = '0;
        repeat (2) @(negedge clk_i);
        chk_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_zero("post_reset");

        run_job("basic",   32'h0000_1000, 16'd4, 16'd8, 32'h40, 0, 0);
        run_job("stall",   32'h0000_1000, 16'd4, 16'd8, 32'h40, 1, 0);
        run_job("empty",   32'h0000_0500, 16'd0, 16'd8, 32'h40, 0, 0);
        run_job("wrap",    32'hFFFF_FFC0, 16'd3, 16'd2, 32'h40, 0, 0);
        run_job("perturb", 32'h0000_8000, 16'd6, 16'd5, 32'h100, 2, 1);
        run_job("len0",    32'h0000_0040, 16'd2, 16'd0, 32'h4, 0, 0);
        run_job("stride0", 32'h1234_5678, 16'd3, 16'd7, 32'h0, 2, 0);

        abort_job("clear", 0);
        run_job("after_clear", 32'h0000_3000, 16'd3, 16'd4, 32'h20, 0, 0);
        abort_job("rst", 1);
        run_job("after_rst", 32'h0000_4000, 16'd2, 16'd9, 32'h8, 0, 0);

        // clear wins over start in the same cycle
        base_addr_i = 32'h0000_7000;
        nb_iter_i   = 16'd3;
        clear_i     = 1'b1;
        start_i     = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        start_i = 1'b0;
        chk_zero("clear_start");
        @(negedge clk_i);
        chk_zero("clear_start_later");
        $display("clear+start same cycle checked");

        for (int j = 0; j < 12; j++) begin
            run_job("random", $urandom, 16'($urandom_range(0, 7)), 16'($urandom),
                    $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
